ysyx_mem_arbiter: RTL and testbench
===================================

YSYX_MEM_ARBITER -- requirements
Module: ysyx_mem_arbiter

Interface
REQ-001 SHALL have ports: clk input 1, clock; rst input 1, reset (synchronous, active-high).
REQ-002 SHALL have ifu_araddr input 32, IFU fetch address; ifu_arvalid input 1, IFU read request.
REQ-003 SHALL have ifu_rvalid output 1, one-cycle IFU read-data-valid pulse.
REQ-004 SHALL have lsu_addr input 32, LSU read/write address; lsu_arvalid input 1, LSU read request.
REQ-005 SHALL have lsu_wdata input 32, LSU store data; lsu_wstrb input 4, byte strobes; lsu_awvalid input 1, LSU write request.
REQ-006 SHALL have lsu_rvalid output 1, LSU read-data-valid pulse; lsu_bvalid output 1, LSU write-done pulse.
REQ-007 SHALL have rdata_o output 32, read data broadcast to both masters, qualified only by ifu_rvalid/lsu_rvalid.
REQ-008 SHALL have mem_addr output 32; mem_arvalid output 1; mem_arready input 1; mem_rdata input 32; mem_rvalid input 1.
REQ-009 SHALL have mem_wdata output 32; mem_wstrb output 4; mem_awvalid output 1 (combined address+data write request); mem_awready input 1; mem_bvalid input 1.

Function
REQ-010 SHALL implement FSM states IDLE, IFU_RD, LSU_RD, LSU_WR; exactly one master granted outside IDLE.
REQ-011 Masters SHALL hold request, address and data stable until their rvalid/bvalid; the arbiter samples them in IDLE and latches address/data into registers on grant.
REQ-012 IDLE arbitration, fixed priority: lsu_awvalid > lsu_arvalid > ifu_arvalid; no request -> stay IDLE.
REQ-013 Grant at edge N -> granting state from cycle N+1, with mem_arvalid or mem_awvalid high from N+1 (registered, no combinational path from master request).
REQ-014 mem_arvalid/mem_awvalid SHALL stay high until the cycle mem_arready/mem_awready is high, then drop next cycle; address/data stable throughout.
REQ-015 After the address handshake, the arbiter waits for mem_rvalid (RD) or mem_bvalid (WR); a response in the same cycle as the handshake SHALL be accepted.
REQ-016 mem_rvalid in IFU_RD -> ifu_rvalid=1 same cycle (combinational); in LSU_RD -> lsu_rvalid=1; rdata_o=mem_rdata in that cycle; mem_bvalid in LSU_WR -> lsu_bvalid=1 same cycle.
REQ-017 Response cycle SHALL return FSM to IDLE; new arbitration in the following cycle (min 2-cycle gap between back-to-back grants).
REQ-018 mem_rvalid/mem_bvalid SHALL be ignored (no upstream pulse) in IDLE or in a non-matching state.
REQ-019 rdata_o SHALL hold the last response value when no rvalid is asserted.
REQ-020 Downstream memory is always ready for responses; no rready/bready ports.

Reset
REQ-021 On rst: state=IDLE, mem_arvalid=mem_awvalid=0, ifu_rvalid=lsu_rvalid=lsu_bvalid=0, mem_addr=mem_wdata=0, mem_wstrb=0, rdata_o=0, round-robin pointer=IFU-last.
REQ-022 Reset mid-transaction SHALL abandon it; stale downstream responses after reset are dropped per REQ-018.

Configuration
REQ-023 With YSYX_ARB_RR_EN defined, read arbitration SHALL be round-robin: when lsu_arvalid and ifu_arvalid are both pending, the master not granted last wins; a pending write still has top priority.
REQ-024 Without YSYX_ARB_RR_EN, fixed priority per REQ-012 applies; the pointer register is not instantiated.

Verification
REQ-025 IFU-only read addr 0x8000_0000, arready after 2 cycles, rvalid with 0x0000_0413 3 cycles later -> one ifu_rvalid pulse, rdata_o=0x0000_0413, lsu_rvalid never high.
REQ-026 ifu_arvalid and lsu_arvalid high together in IDLE -> without RR, LSU granted first, IFU next; with RR after prior LSU grant, IFU granted first.
REQ-027 lsu_awvalid addr 0x8000_0100, wdata 0xDEAD_BEEF, wstrb 0xF, awready and bvalid same cycle -> mem_awvalid drops next cycle, one lsu_bvalid pulse, FSM IDLE.
REQ-028 rst asserted during IFU_RD before mem_rvalid, then mem_rvalid arrives -> no ifu_rvalid pulse; all outputs at reset values.
REQ-029 Spurious mem_rvalid in IDLE with mem_rdata=0x1234_5678 -> no upstream pulse, rdata_o unchanged.

Source files
------------

// File: rtl/ysyx_mem_arbiter.sv
// ysyx_mem_arbiter: shares one downstream memory port between the IFU
// (read only) and the LSU (read/write). One transaction is in flight at a
// time. Writes always win arbitration. Between the two readers, LSU wins by
// default. Define YSYX_ARB_RR_EN to make read arbitration round-robin.
// Read data is broadcast on rdata_o and is qualified by ifu_rvalid/lsu_rvalid.
module ysyx_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_rvalid,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_arvalid,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_awvalid,
    output logic        lsu_rvalid,
    output logic        lsu_bvalid,
    output logic [31:0] rdata_o,
    output logic [31:0] mem_addr,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_awvalid,
    input  logic        mem_awready,
    input  logic        mem_bvalid
);

    typedef enum logic [1:0] {
        IDLE,
        IFU_RD,
        LSU_RD,
        LSU_WR
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        arvalid_q, arvalid_d;
    logic        awvalid_q, awvalid_d;

    logic        grant_wr;
    logic        grant_lsu;
    logic        grant_ifu;
    logic        rd_addr_done;
    logic        wr_addr_done;

`ifdef YSYX_ARB_RR_EN
    // Set when the most recent read grant went to the LSU.
    logic        last_lsu_q, last_lsu_d;
`endif

    // Arbitration among requests sampled in IDLE.
    always_comb begin
        grant_wr  = lsu_awvalid;
`ifdef YSYX_ARB_RR_EN
        grant_ifu = !lsu_awvalid && ifu_arvalid && (!lsu_arvalid || last_lsu_q);
`else
        grant_ifu = !lsu_awvalid && ifu_arvalid && !lsu_arvalid;
`endif
        grant_lsu = !lsu_awvalid && lsu_arvalid && !grant_ifu;
    end

`ifdef YSYX_ARB_RR_EN
    // Next value of the round-robin pointer. Only read grants move it.
    always_comb begin
        last_lsu_d = last_lsu_q;
        if (state_q == IDLE && (grant_ifu || grant_lsu)) begin
            last_lsu_d = grant_lsu;
        end
    end

    // Round-robin pointer register. Reset marks the IFU as granted last.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_lsu_q <= 1'b0;
        end else begin
            last_lsu_q <= last_lsu_d;
        end
    end
`endif

    // Next state, latched request fields and upstream response pulses.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        arvalid_d  = arvalid_q;
        awvalid_d  = awvalid_q;
        ifu_rvalid = 1'b0;
        lsu_rvalid = 1'b0;
        lsu_bvalid = 1'b0;

        // A response counts once the address phase is over, including the
        // cycle in which the address handshake itself completes.
        rd_addr_done = !arvalid_q || mem_arready;
        wr_addr_done = !awvalid_q || mem_awready;

        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    state_d   = LSU_WR;
                    addr_d    = lsu_addr;
                    wdata_d   = lsu_wdata;
                    wstrb_d   = lsu_wstrb;
                    awvalid_d = 1'b1;
                end else if (grant_lsu) begin
                    state_d   = LSU_RD;
                    addr_d    = lsu_addr;
                    arvalid_d = 1'b1;
                end else if (grant_ifu) begin
                    state_d   = IFU_RD;
                    addr_d    = ifu_araddr;
                    arvalid_d = 1'b1;
                end
            end
            IFU_RD, LSU_RD: begin
                if (arvalid_q && mem_arready) begin
                    arvalid_d = 1'b0;
                end
                if (mem_rvalid && rd_addr_done) begin
                    ifu_rvalid = (state_q == IFU_RD);
                    lsu_rvalid = (state_q == LSU_RD);
                    rdata_d    = mem_rdata;
                    arvalid_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            LSU_WR: begin
                if (awvalid_q && mem_awready) begin
                    awvalid_d = 1'b0;
                end
                if (mem_bvalid && wr_addr_done) begin
                    lsu_bvalid = 1'b1;
                    awvalid_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The reset cycle abandons the transaction, so it must not produce
        // a response pulse either.
        if (rst) begin
            ifu_rvalid = 1'b0;
            lsu_rvalid = 1'b0;
            lsu_bvalid = 1'b0;
        end
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
        end
    end

    // Forward memory data in the response cycle and hold it afterwards.
    always_comb begin
        rdata_o = (ifu_rvalid || lsu_rvalid) ? mem_rdata : rdata_q;
    end

    assign mem_addr    = addr_q;
    assign mem_arvalid = arvalid_q;
    assign mem_awvalid = awvalid_q;
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = wstrb_q;

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Scoreboard bench for ysyx_mem_arbiter. Master drivers push the responses
// they expect. A memory responder checks each downstream request and
// answers it. A monitor pops the expected responses and compares them.
`timescale 1ns/1ps
module tb_ysyx_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_rvalid;
    logic [31:0] lsu_addr;
    logic        lsu_arvalid;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_awvalid;
    logic        lsu_rvalid;
    logic        lsu_bvalid;
    logic [31:0] rdata_o;
    logic [31:0] mem_addr;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_awvalid;
    logic        mem_awready;
    logic        mem_bvalid;

    always #5 clk = ~clk;

    ysyx_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_rvalid(ifu_rvalid),
        .lsu_addr(lsu_addr), .lsu_arvalid(lsu_arvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_awvalid(lsu_awvalid),
        .lsu_rvalid(lsu_rvalid), .lsu_bvalid(lsu_bvalid), .rdata_o(rdata_o),
        .mem_addr(mem_addr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_awvalid(mem_awvalid),
        .mem_awready(mem_awready), .mem_bvalid(mem_bvalid)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
    } lsu_exp_t;

    logic [31:0] ifu_q [$];
    lsu_exp_t    lsu_q [$];
    logic [31:0] grant_q [$];
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] mem_store [logic [31:0]];

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_rd;
    bit          rand_lat;
    int unsigned cfg_ar_wait, cfg_r_wait;
    int unsigned spur_cnt;
    bit          ifu_pend, lsu_pend, lsu_pend_wr;
    logic [31:0] ifu_pend_addr, lsu_pend_addr, lsu_pend_wdata;
    logic [3:0]  lsu_pend_wstrb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h8000_0413;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] store_rd(input logic [31:0] a);
        return mem_store.exists(a) ? mem_store[a] : init_word(a);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- master drivers ----------------
    task automatic ifu_read(input logic [31:0] a, input bit tchk);
        bit got;
        ifu_araddr = a; ifu_pend_addr = a; ifu_pend = 1'b1; ifu_arvalid = 1'b1;
        ifu_q.push_back(ref_rd(a));
        if (tchk) begin
            @(negedge clk); chk("ar_not_combinational", {31'b0, mem_arvalid}, 0);
            @(negedge clk); chk("ar_after_grant", {31'b0, mem_arvalid}, 1);
        end
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (ifu_rvalid) got = 1'b1;
        end
        chk("ifu_done", {31'b0, got}, 1);
        step();
        ifu_arvalid = 1'b0; ifu_pend = 1'b0;
    endtask

    task automatic lsu_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        bit got;
        lsu_addr = a; lsu_wdata = d; lsu_wstrb = s;
        lsu_pend_addr = a; lsu_pend_wdata = d; lsu_pend_wstrb = s;
        lsu_pend_wr = wr; lsu_pend = 1'b1;
        if (wr) begin
            ref_mem[a] = merge(ref_rd(a), d, s);
            lsu_q.push_back('{wr: 1'b1, data: 32'h0});
            lsu_awvalid = 1'b1;
        end else begin
            lsu_q.push_back('{wr: 1'b0, data: ref_rd(a)});
            lsu_arvalid = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (lsu_rvalid || lsu_bvalid) got = 1'b1;
        end
        chk("lsu_done", {31'b0, got}, 1);
        step();
        lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_pend = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_mem_arvalid", {31'b0, mem_arvalid}, 0);
        chk("rst_mem_awvalid", {31'b0, mem_awvalid}, 0);
        chk("rst_ifu_rvalid", {31'b0, ifu_rvalid}, 0);
        chk("rst_lsu_rvalid", {31'b0, lsu_rvalid}, 0);
        chk("rst_lsu_bvalid", {31'b0, lsu_bvalid}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 0);
        chk("rst_rdata", rdata_o, 0);
    endtask

    // ---------------- memory responder ----------------
    task automatic clear_mem();
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_awready = 1'b0; mem_bvalid = 1'b0;
        mem_rdata = $urandom();
    endtask

    initial begin : responder
        logic [31:0] a, rd;
        bit          wr;
        int unsigned aw, rw, spur_done;
        spur_done = 0;
        clear_mem();
        forever begin
            step();
            clear_mem();
            if (rst !== 1'b0) continue;
            if (spur_cnt != spur_done) begin
                spur_done++;
                mem_rvalid = 1'b1;
                mem_rdata  = 32'h1234_5678;
            end else if (mem_arvalid || mem_awvalid) begin
                wr = mem_awvalid; a = mem_addr; rd = '0;
                chk("single_request", {31'b0, mem_arvalid & mem_awvalid}, 0);
                if (grant_q.size() > 0) chk("grant_order", a, grant_q.pop_front());
                if (wr) begin
                    chk("wr_pending", {31'b0, lsu_pend & lsu_pend_wr}, 1);
                    chk("wr_addr", a, lsu_pend_addr);
                    chk("wr_data", mem_wdata, lsu_pend_wdata);
                    chk("wr_strb", {28'b0, mem_wstrb}, {28'b0, lsu_pend_wstrb});
                end else begin
                    chk("rd_pending", {31'b0, (ifu_pend && a == ifu_pend_addr) ||
                        (lsu_pend && !lsu_pend_wr && a == lsu_pend_addr)}, 1);
                end
                aw = rand_lat ? $urandom_range(3, 0) : cfg_ar_wait;
                rw = rand_lat ? $urandom_range(3, 0) : cfg_r_wait;
                for (int unsigned i = 0; i < aw; i++) begin
                    step();
                    clear_mem();
                    chk("req_hold", {31'b0, wr ? mem_awvalid : mem_arvalid}, 1);
                    chk("addr_hold", mem_addr, a);
                end
                if (wr) begin
                    mem_store[a] = merge(store_rd(a), mem_wdata, mem_wstrb);
                    mem_awready = 1'b1;
                end else begin
                    rd = store_rd(a);
                    mem_arready = 1'b1;
                end
                if (rw == 0) begin
                    if (wr) mem_bvalid = 1'b1;
                    else begin mem_rvalid = 1'b1; mem_rdata = rd; end
                end
                step();
                clear_mem();
                chk("req_drop", {31'b0, wr ? mem_awvalid : mem_arvalid}, 0);
                if (rw > 0) begin
                    for (int unsigned i = 1; i < rw; i++) begin
                        step();
                        clear_mem();
                    end
                    if (wr) mem_bvalid = 1'b1;
                    else begin mem_rvalid = 1'b1; mem_rdata = rd; end
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin : monitor
        lsu_exp_t    e;
        logic [31:0] x;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            if (ifu_rvalid || lsu_rvalid || lsu_bvalid)
                chk("pulse_count", 32'(ifu_rvalid) + 32'(lsu_rvalid) + 32'(lsu_bvalid), 1);
            if (ifu_rvalid) begin
                if (ifu_q.size() == 0) chk("ifu_unexpected_pulse", {31'b0, ifu_rvalid}, 0);
                else begin
                    x = ifu_q.pop_front();
                    chk("ifu_rdata", rdata_o, x);
                    last_rd = x;
                end
            end
            if (lsu_rvalid || lsu_bvalid) begin
                if (lsu_q.size() == 0)
                    chk("lsu_unexpected_pulse", {31'b0, lsu_rvalid | lsu_bvalid}, 0);
                else begin
                    e = lsu_q.pop_front();
                    chk("lsu_kind", {31'b0, lsu_bvalid}, {31'b0, e.wr});
                    if (lsu_rvalid) begin
                        chk("lsu_rdata", rdata_o, e.data);
                        last_rd = e.data;
                    end
                end
            end
            if (!ifu_rvalid && !lsu_rvalid) chk("rdata_hold", rdata_o, last_rd);
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        bit got;
        rst = 1'b1;
        ifu_araddr = '0; ifu_arvalid = 1'b0;
        lsu_addr = '0; lsu_arvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_awvalid = 1'b0;
        last_rd = '0; rand_lat = 1'b0; cfg_ar_wait = 0; cfg_r_wait = 0; spur_cnt = 0;
        ifu_pend = 1'b0; lsu_pend = 1'b0; lsu_pend_wr = 1'b0;
        ifu_pend_addr = '0; lsu_pend_addr = '0; lsu_pend_wdata = '0; lsu_pend_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        step();
        rst = 1'b0;
        step();

        // IFU-only fetch: arready after 2 cycles, data 3 cycles later
        cfg_ar_wait = 2; cfg_r_wait = 3;
        ifu_read(32'h8000_0000, 1'b1);
        chk("ifu_fetch_hold", rdata_o, 32'h0000_0413);

        // Spurious response while idle
        spur_cnt++;
        repeat (4) step();
        chk("spurious_rdata_hold", rdata_o, 32'h0000_0413);

        // Write with awready and bvalid in the same cycle
        cfg_ar_wait = 1; cfg_r_wait = 0;
        lsu_op(1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'hF);

        // Both readers together, IFU granted last: LSU first in both modes
        cfg_ar_wait = 1; cfg_r_wait = 1;
        grant_q.push_back(32'h8002_0010);
        grant_q.push_back(32'h8000_1004);
        fork
            ifu_read(32'h8000_1004, 1'b0);
            lsu_op(1'b0, 32'h8002_0010, 32'h0, 4'h0);
        join
        step();

        // LSU granted last, then both readers together
        lsu_op(1'b0, 32'h8002_0014, 32'h0, 4'h0);
        step();
`ifdef YSYX_ARB_RR_EN
        grant_q.push_back(32'h8000_1008);
        grant_q.push_back(32'h8002_0018);
`else
        grant_q.push_back(32'h8002_0018);
        grant_q.push_back(32'h8000_1008);
`endif
        fork
            ifu_read(32'h8000_1008, 1'b0);
            lsu_op(1'b0, 32'h8002_0018, 32'h0, 4'h0);
        join
        step();

        // A pending write beats a pending IFU read
        grant_q.push_back(32'h8002_0018);
        grant_q.push_back(32'h8000_100C);
        fork
            ifu_read(32'h8000_100C, 1'b0);
            lsu_op(1'b1, 32'h8002_0018, 32'hCAFE_0001, 4'h5);
        join
        step();
        lsu_op(1'b0, 32'h8002_0018, 32'h0, 4'h0);
        step();

        // Reset during IFU_RD after the address handshake; response arrives later
        cfg_ar_wait = 0; cfg_r_wait = 5;
        ifu_araddr = 32'h8000_1100; ifu_pend_addr = 32'h8000_1100; ifu_pend = 1'b1;
        ifu_arvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mem_arvalid) got = 1'b1;
        end
        chk("rst_test_request", {31'b0, got}, 1);
        step();
        rst = 1'b1; ifu_arvalid = 1'b0; ifu_pend = 1'b0; last_rd = '0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_reset();
        repeat (8) step();

        // Randomized traffic from both masters
        rand_lat = 1'b1;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    int unsigned g;
                    g = $urandom_range(3, 0);
                    repeat (g) step();
                    ifu_read(32'h8000_1000 + 32'($urandom_range(63, 0) << 2), 1'b0);
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    int unsigned g;
                    g = $urandom_range(3, 0);
                    repeat (g) step();
                    lsu_op(1'($urandom_range(1, 0)),
                           32'h8002_0000 + 32'($urandom_range(15, 0) << 2),
                           $urandom(), 4'($urandom_range(15, 0)));
                end
            end
        join
        repeat (6) step();
        chk("ifu_queue_drained", 32'(ifu_q.size()), 0);
        chk("lsu_queue_drained", 32'(lsu_q.size()), 0);
        chk("grant_queue_drained", 32'(grant_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
